debounce_botoes: RTL and testbench
==================================

DEBOUNCE_BOTOES -- requirements
Module: debounce_botoes

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 500000, giving the number of consecutive stable clk cycles needed to accept a button change (10 ms at 50 MHz); legal range >= 1.
REQ-002 The block SHALL have parameter REPEAT_CYCLES, default 25000000, giving the hold-repeat period in clk cycles; legal range >= 1.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 btn1..btn4  input  1 each  raw, asynchronous, bouncing push-buttons; 0 = pressed.
REQ-007 btn_n  output  4  debounced levels, bit i-1 = btnI; 0 = pressed; drop-in for the stopwatch button inputs.
REQ-008 press  output  4  one-cycle active-high press pulses, bit i-1 = btnI.
REQ-009 any_press  output  1  OR of press[3:0], same cycle.

Function
REQ-010 Each btnI SHALL pass through its own 2-flop synchronizer, reset value 1; only the second flop output (sync) SHALL feed debounce logic.
REQ-011 Each channel SHALL hold a stable value (drives btn_n bit) and a counter sized ceil(log2(DEBOUNCE_CYCLES+1)) bits.
REQ-012 While sync equals stable, the counter SHALL be 0.
REQ-013 While sync differs from stable, the counter SHALL increment by 1 per cycle; any cycle where sync returns to stable clears it to 0, so a glitch shorter than DEBOUNCE_CYCLES is discarded.
REQ-014 On the cycle the counter would reach DEBOUNCE_CYCLES, stable SHALL take sync and the counter SHALL clear to 0.
REQ-015 Latency: a clean level change on btnI held indefinitely SHALL appear on btn_n exactly DEBOUNCE_CYCLES+2 rising edges after the first edge that samples it.
REQ-016 press[i] SHALL be 1 for exactly the one cycle in which btn_n[i] goes 1->0; a release (0->1) SHALL produce no pulse.
REQ-017 Channels SHALL be fully independent; simultaneous presses SHALL produce simultaneous press bits, no priority or masking.
REQ-018 Counters SHALL never wrap: the counter saturates via REQ-014 and never exceeds DEBOUNCE_CYCLES-1 when registered.
REQ-019 All outputs SHALL be registered (press and btn_n driven from flops; any_press may be the combinational OR of registered press).

Reset
REQ-020 While rst_n=0: synchronizers=1, btn_n=4'b1111, press=0, any_press=0, all counters=0, regardless of clk.
REQ-021 Reset mid-debounce SHALL discard the partial count; a button held low through reset deassertion SHALL yield its press pulse DEBOUNCE_CYCLES+2 edges after the first post-reset edge (it is treated as a fresh press).
REQ-022 Reset deassertion needs no synchronizer inside this block; the system reset is released synchronously upstream.

Configuration
REQ-023 Macro BTN_HOLD_REPEAT_EN: when defined, each channel SHALL have a repeat counter cleared on the press pulse and on release; while btn_n[i]=0 it SHALL re-pulse press[i] every REPEAT_CYCLES cycles, i.e. at P, P+REPEAT_CYCLES, P+2*REPEAT_CYCLES, ... where P is the first pulse cycle.
REQ-024 Without BTN_HOLD_REPEAT_EN, exactly one press pulse per debounced press SHALL occur, no repeat counters SHALL be synthesized, and REPEAT_CYCLES SHALL be ignored.

Verification (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8)
REQ-025 btn1 1->0 held from edge 0 -> btn_n[0]=0 and press[0]=1 at edge 6 only; any_press=1 same cycle; press[0]=0 at edge 7.
REQ-026 btn2 low 3 cycles then high (bounce) -> btn_n[1] stays 1, press[1] never asserts.
REQ-027 btn3 and btn4 fall on same edge -> press[2] and press[3] both 1 on same cycle, one cycle wide.
REQ-028 btn1 held, rst_n pulsed low at edge 3 for 2 cycles -> outputs at reset values during reset; press[0] at 6th edge after rst_n release.
REQ-029 btn1 pressed then released after 20 cycles -> btn_n[0] returns to 1 six edges after release, no pulse on release.
REQ-030 With BTN_HOLD_REPEAT_EN, btn1 held 30 cycles after pulse at P -> pulses at P, P+8, P+16, P+24, none after release; without macro -> single pulse at P.

Source files
------------

// File: rtl/debounce_botoes.sv
// Four-channel push-button conditioner: 2-flop synchronizer, stable-count debounce, press pulses.
// Optional hold-repeat of press pulses is enabled by defining BTN_HOLD_REPEAT_EN.
module debounce_botoes #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_CYCLES   = 25000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn1,
  input  logic       btn2,
  input  logic       btn3,
  input  logic       btn4,
  output logic [3:0] btn_n,
  output logic [3:0] press,
  output logic       any_press
);

  localparam int unsigned N_BTN = 4;
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_BTN-1:0] w_btn_raw;
  logic [N_BTN-1:0] r_sync1;
  logic [N_BTN-1:0] r_sync2;
  logic [N_BTN-1:0] r_stable;
  logic [N_BTN-1:0] w_stable_nxt;
  logic [N_BTN-1:0] r_btn_n;
  logic [N_BTN-1:0] r_press;
  logic [N_BTN-1:0] w_press_nxt;
  logic [CNT_W-1:0] r_cnt     [N_BTN];
  logic [CNT_W-1:0] w_cnt_nxt [N_BTN];

  assign w_btn_raw = {btn4, btn3, btn2, btn1};

  // Two-flop synchronizer; idle (released) level is 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= w_btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  // A change is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    w_stable_nxt = r_stable;
    for (int i = 0; i < N_BTN; i++) begin
      w_cnt_nxt[i] = '0;
      if (r_sync2[i] != r_stable[i]) begin
        if (r_cnt[i] == CNT_LAST) begin
          w_stable_nxt[i] = r_sync2[i];
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stable <= '1;
      r_btn_n  <= '1;
      r_press  <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_stable <= w_stable_nxt;
      r_btn_n  <= r_stable;
      r_press  <= w_press_nxt;
      for (int i = 0; i < N_BTN; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
    end
  end

`ifdef BTN_HOLD_REPEAT_EN
  localparam int unsigned RPT_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

  logic [RPT_W-1:0] r_rpt     [N_BTN];
  logic [RPT_W-1:0] w_rpt_nxt [N_BTN];

  // First pulse on the debounced fall, then one every REPEAT_CYCLES while still held.
  always_comb begin
    w_press_nxt = '0;
    for (int i = 0; i < N_BTN; i++) begin
      w_rpt_nxt[i] = '0;
      if (!r_stable[i]) begin
        if (r_btn_n[i]) begin
          w_press_nxt[i] = 1'b1;
        end else if (r_rpt[i] == RPT_LAST) begin
          w_press_nxt[i] = 1'b1;
        end else begin
          w_rpt_nxt[i] = r_rpt[i] + RPT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_BTN; i++) begin
        r_rpt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        r_rpt[i] <= w_rpt_nxt[i];
      end
    end
  end
`else
  // Single pulse on the cycle the registered level goes 1->0.
  always_comb begin
    w_press_nxt = r_btn_n & ~r_stable;
  end
`endif

  assign btn_n     = r_btn_n;
  assign press     = r_press;
  assign any_press = |r_press;

endmodule

// File: tb/tb_debounce_botoes.sv
// Directed bench for debounce_botoes (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8) with a run-length reference model.
module tb_debounce_botoes;

  localparam int unsigned D = 4;
  localparam int unsigned R = 8;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn1  = 1'b1;
  logic       btn2  = 1'b1;
  logic       btn3  = 1'b1;
  logic       btn4  = 1'b1;
  logic [3:0] btn_n;
  logic [3:0] press;
  logic       any_press;

  debounce_botoes #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_CYCLES  (R)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn1     (btn1),
    .btn2     (btn2),
    .btn3     (btn3),
    .btn4     (btn4),
    .btn_n    (btn_n),
    .press    (press),
    .any_press(any_press)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %b, want %b", name, cyc, act, exp);
    end
  endtask

  // Reference model: a raw level must be seen D consecutive samples in a row to be
  // accepted; the accepted level reaches btn_n three edges after its last sample.
  logic [3:0] m_cur;
  logic [3:0] m_d [5];
  int         m_run [4];
  int         m_held [4];
  logic [3:0] exp_btn_n = 4'hF;
  logic [3:0] exp_press = 4'h0;

  always @(posedge clk) begin
    logic [3:0] raw;
    cyc++;
    if (!rst_n) begin
      m_cur = 4'hF;
      for (int k = 0; k < 5; k++) m_d[k] = 4'hF;
      for (int c = 0; c < 4; c++) begin
        m_run[c]  = 0;
        m_held[c] = 0;
      end
      exp_btn_n = 4'hF;
      exp_press = 4'h0;
    end else begin
      raw = {btn4, btn3, btn2, btn1};
      for (int c = 0; c < 4; c++) begin
        m_run[c] = (raw[c] !== m_cur[c]) ? m_run[c] + 1 : 0;
        if (m_run[c] == D) begin
          m_cur[c] = ~m_cur[c];
          m_run[c] = 0;
        end
      end
      for (int k = 4; k > 0; k--) m_d[k] = m_d[k-1];
      m_d[0]    = m_cur;
      exp_btn_n = m_d[3];
      for (int c = 0; c < 4; c++) begin
`ifdef BTN_HOLD_REPEAT_EN
        if (!m_d[3][c]) begin
          m_held[c]    = m_d[4][c] ? 0 : m_held[c] + 1;
          exp_press[c] = ((m_held[c] % R) == 0);
        end else begin
          m_held[c]    = 0;
          exp_press[c] = 1'b0;
        end
`else
        exp_press[c] = m_d[4][c] & ~m_d[3][c];
`endif
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic [3:0] eb;
    logic [3:0] ep;
    #1;
    eb = rst_n ? exp_btn_n : 4'hF;
    ep = rst_n ? exp_press : 4'h0;
    check("cmp_btn_n", btn_n, eb);
    check("cmp_press", press, ep);
    check("cmp_any_press", {3'b000, any_press}, {3'b000, |ep});
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    {btn4, btn3, btn2, btn1} = 4'hF;
    tick(2);
    check("rst_btn_n", btn_n, 4'hF);
    check("rst_press", press, 4'h0);
    check("rst_any", {3'b000, any_press}, 4'h0);
    rst_n = 1'b1;
  endtask

  logic [3:0] pat_val [6];
  int         pat_len [6];

  initial begin
    tick(1);
    do_reset();

    // Clean press on btn1, then release after 20 held cycles.
    btn1 = 1'b0;
    tick(6);
    check("t1_btn_n_e5", btn_n, 4'hF);
    check("t1_press_e5", press, 4'h0);
    tick(1);
    check("t1_btn_n_e6", btn_n, 4'hE);
    check("t1_press_e6", press, 4'h1);
    check("t1_any_e6", {3'b000, any_press}, 4'h1);
    check("t1_model_press_e6", exp_press, 4'h1);
    tick(1);
    check("t1_press_e7", press, 4'h0);
    check("t1_btn_n_e7", btn_n, 4'hE);
    tick(19);
    btn1 = 1'b1;
    tick(6);
    check("t1_rel_btn_n_r5", btn_n, 4'hE);
    tick(1);
    check("t1_rel_btn_n_r6", btn_n, 4'hF);
    check("t1_rel_press_r6", press, 4'h0);
    tick(4);

    // Bounces shorter than D are discarded; a low of exactly D samples is accepted.
    do_reset();
    btn2 = 1'b0; tick(3);
    btn2 = 1'b1; tick(1);
    btn2 = 1'b0; tick(3);
    btn2 = 1'b1; tick(12);
    check("t2_bounce_btn_n", btn_n, 4'hF);
    check("t2_model_btn_n", exp_btn_n, 4'hF);
    btn2 = 1'b0; tick(4);
    btn2 = 1'b1; tick(3);
    check("t2_edge_press", press, 4'h2);
    check("t2_edge_btn_n", btn_n, 4'hD);
    tick(8);

    // Simultaneous presses on btn3 and btn4.
    do_reset();
    btn3 = 1'b0;
    btn4 = 1'b0;
    tick(7);
    check("t3_press_e6", press, 4'hC);
    check("t3_any_e6", {3'b000, any_press}, 4'h1);
    tick(1);
    check("t3_press_e7", press, 4'h0);
    check("t3_btn_n_e7", btn_n, 4'h3);
    btn3 = 1'b1;
    btn4 = 1'b1;
    tick(10);

    // Reset mid-debounce while btn1 stays low.
    do_reset();
    btn1 = 1'b0;
    tick(3);
    rst_n = 1'b0;
    tick(1);
    check("t4_in_rst_btn_n", btn_n, 4'hF);
    check("t4_in_rst_press", press, 4'h0);
    tick(1);
    rst_n = 1'b1;
    tick(6);
    check("t4_press_e5", press, 4'h0);
    check("t4_btn_n_e5", btn_n, 4'hF);
    tick(1);
    check("t4_press_e6", press, 4'h1);
    tick(2);
    btn1 = 1'b1;
    tick(10);

    // Long hold: repeats at P+8k only when the repeat option is built in.
    do_reset();
    btn1 = 1'b0;
    tick(7);
    check("t5_press_p", press, 4'h1);
    tick(7);
    check("t5_press_p7", press, 4'h0);
    tick(1);
`ifdef BTN_HOLD_REPEAT_EN
    check("t5_press_p8", press, 4'h1);
`else
    check("t5_press_p8", press, 4'h0);
`endif
    tick(15);
    btn1 = 1'b1;
    tick(1);
`ifdef BTN_HOLD_REPEAT_EN
    check("t5_press_p24", press, 4'h1);
`else
    check("t5_press_p24", press, 4'h0);
`endif
    tick(8);
    check("t5_press_p32", press, 4'h0);
    check("t5_btn_n_p32", btn_n, 4'hF);
    tick(8);

    // Mixed multi-channel pattern, checked by the model only.
    do_reset();
    pat_val[0] = 4'b1010; pat_len[0] = 5;
    pat_val[1] = 4'b0101; pat_len[1] = 2;
    pat_val[2] = 4'b0000; pat_len[2] = 6;
    pat_val[3] = 4'b1111; pat_len[3] = 3;
    pat_val[4] = 4'b0110; pat_len[4] = 9;
    pat_val[5] = 4'b1111; pat_len[5] = 12;
    for (int p = 0; p < 6; p++) begin
      {btn4, btn3, btn2, btn1} = pat_val[p];
      tick(pat_len[p]);
    end
    check("t6_final_btn_n", btn_n, 4'hF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
